gsim_residual: RTL and testbench
================================

Name: gsim_residual

Overview:
- Downstream checker for the GSIM solver. Taps the same b stream that feeds GSIM and consumes GSIM's 16 solution words.
- Computes the hardware residual r = M·x − b for the fixed 16×16 band matrix. Each row of M is (−1, 6, −13, 20, −13, 6, −1) centred on the diagonal.
- Streams the per-row residuals, then reports the maximum absolute residual and a pass flag. Used for on-chip self-check of solver convergence.

Parameters:
N, 16, vector length (fixed band structure; only 16 supported)
RW, 40, signed residual width (Q(RW−16).16)
TOL, 40'h0000000100, pass threshold on max |r| (Q.16; default 2^-8)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_en  input  1  b word valid (same strobe that drives GSIM)
b_in  input  16  b element, signed Q16.0, index order 0..15
x_valid  input  1  GSIM out_valid
x_in  input  32  GSIM x_out, signed Q16.16, index order 0..15
r_valid  output  1  residual word valid
r_idx  output  4  row index of r_out
r_out  output  RW  residual row r_idx, signed Q.16
done  output  1  one-cycle pulse, frame finished
max_abs  output  RW  max |r_i| over frame (unsigned magnitude)
res_ok  output  1  max_abs < TOL, valid from done onward

Behaviour:
- Reset (async, high): state IDLE, counters cleared, buffers 0. All outputs 0 except res_ok=0.
- State IDLE/LOAD: b_cnt increments on each in_en and stores b_in to b_buf[b_cnt]. x_cnt increments on each x_valid and stores x_in to x_buf[x_cnt].
- The b and x streams are independent and may overlap in the same cycle.
- Writes after a counter reaches 16 are ignored: no wrap, no overwrite.
- LOAD→COMPUTE occurs on the clock edge where both counters equal 16.
- COMPUTE: one row per cycle, row i = 0..15.
  - Mx_i = 20x_i − 13(x_{i−1} + x_{i+1}) + 6(x_{i−2} + x_{i+2}) − (x_{i−3} + x_{i+3}).
  - Out-of-range indices contribute 0.
  - Constant multiplies are built from shifts and adds only; no multipliers.
- Arithmetic: x is sign-extended to RW. b is sign-extended and shifted left 16 (Q16.0→Q.16). r_i = Mx_i − b_i, exact with no saturation (38 bits suffice; RW=40 gives margin).
- Output timing: r_valid=1 with r_idx=i and r_out=r_i, registered one cycle after row i's compute cycle. This gives 16 consecutive r_valid cycles with no gaps. r_out and r_idx hold their last value when r_valid=0.
- max_abs: cleared on entry to COMPUTE, updated with |r_i| each row. |most-negative| does not occur at RW=40.
- DONE: done=1 for exactly one cycle, the cycle after the last r_valid. At the same edge res_ok = (max_abs < TOL).
  - max_abs and res_ok hold until the next frame starts.
  - The state then returns to IDLE with counters cleared.
- New frame: in_en or x_valid arriving in IDLE begins loading. These writes are accepted even in the cycle done is high.
- in_en or x_valid during COMPUTE is ignored. The source protocol (GSIM) never does this.
- Reset mid-operation: everything is cleared immediately and the partial frame is discarded. The next full frame behaves normally.

Test Plan:
- All b=0x0000, all x=0x00000000 → 16 r_valid, every r_out=0, done pulse, max_abs=0, res_ok=1.
- b all 0, x[8]=0x00010000, others 0 → r_idx 5..11 = −1.0, 6.0, −13.0, 20.0, −13.0, 6.0, −1.0 (20.0 = 40'h0000140000), others 0; max_abs=0x140000, res_ok=0.
- Edge: b all 0, x[0]=0x00010000 only → r0=20.0, r1=−13.0, r2=6.0, r3=−1.0, r4..r15=0. Checks zero padding at the left boundary; mirror with x[15] for the right.
- Sign handling: b all 0xFFFF (−1), x all 0 → every r_out=+1.0 (0x10000), max_abs=0x10000.
- Timing/overflow: b stream of 17 words, then x 16 words after a 5-cycle gap → 17th b ignored. First r_valid appears 2 cycles after the 16th x_valid, r_valid lasts 16 cycles, done follows immediately.
- Assert reset at row 7 of COMPUTE → outputs 0 asynchronously. Then replay the impulse frame → results identical to the second scenario.

Source files
------------

// File: rtl/gsim_residual.sv
// gsim_residual: residual checker r = M*x - b for the 16x16 band matrix
// (-1,6,-13,20,-13,6,-1), with streamed rows, max |r| and a pass flag.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   in_en, b_in       b word strobe / signed Q16.0 element (index 0..15)
//   x_valid, x_in     solution strobe / signed Q16.16 element (index 0..15)
//   r_valid, r_idx    residual strobe / row index
//   r_out             residual row, signed Q.16, RW bits
//   done              one-cycle end-of-frame pulse
//   max_abs, res_ok   max |r| over frame, and max_abs < TOL
module gsim_residual #(
    parameter int N = 16,
    parameter int RW = 40,
    parameter logic [RW-1:0] TOL = 40'h0000000100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [15:0]   b_in,
    input  logic          x_valid,
    input  logic [31:0]   x_in,
    output logic          r_valid,
    output logic [3:0]    r_idx,
    output logic [RW-1:0] r_out,
    output logic          done,
    output logic [RW-1:0] max_abs,
    output logic          res_ok
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, FIN} state_t;

    state_t state, state_nxt;

    logic [15:0]   b_buf [N];
    logic [31:0]   x_buf [N];
    logic [CW-1:0] b_cnt, x_cnt;
    logic [3:0]    row;

    logic b_we, x_we, b_full, x_full, start, comp, fin;

    // x padded with three zero words on each side so the band taps of the
    // boundary rows read zeros instead of needing range checks.
    logic [RW-1:0] xe [N+6];
    logic [RW-1:0] t0, t1, t2, t3, t4, t5, t6;
    logic [RW-1:0] s1, s2, s3, mx, bx, r, r_abs;
    logic [4:0]    base;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_en || x_valid) state_nxt = LOAD;
            LOAD:    if (start) state_nxt = COMPUTE;
            COMPUTE: if (row == 4'(N-1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs. The frame starts computing on the edge where the
    // last missing word lands, so "full" looks one write ahead.
    always_comb begin
        b_we   = (state == IDLE || state == LOAD) && in_en && (b_cnt != CW'(N));
        x_we   = (state == IDLE || state == LOAD) && x_valid && (x_cnt != CW'(N));
        b_full = (b_cnt == CW'(N)) || ((b_cnt == CW'(N-1)) && b_we);
        x_full = (x_cnt == CW'(N)) || ((x_cnt == CW'(N-1)) && x_we);
        start  = (state == LOAD) && b_full && x_full;
        comp   = (state == COMPUTE);
        fin    = (state == FIN);
    end

    always_comb begin
        for (int m = 0; m < N + 6; m++) xe[m] = '0;
        for (int m = 0; m < N; m++)
            xe[m+3] = {{(RW-32){x_buf[m][31]}}, x_buf[m]};
    end

    // Row arithmetic, shift-and-add only:
    // 20c = 16c+4c, 13s = 8s+4s+s, 6s = 4s+2s.
    always_comb begin
        base  = {1'b0, row};
        t0    = xe[base];
        t1    = xe[base + 5'd1];
        t2    = xe[base + 5'd2];
        t3    = xe[base + 5'd3];
        t4    = xe[base + 5'd4];
        t5    = xe[base + 5'd5];
        t6    = xe[base + 5'd6];
        s1    = t2 + t4;
        s2    = t1 + t5;
        s3    = t0 + t6;
        mx    = (t3 << 4) + (t3 << 2)
              - ((s1 << 3) + (s1 << 2) + s1)
              + ((s2 << 2) + (s2 << 1))
              - s3;
        bx    = {{(RW-32){b_buf[row][15]}}, b_buf[row], 16'h0000};
        r     = mx - bx;
        r_abs = r[RW-1] ? (~r + 1'b1) : r;
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_cnt   <= '0;
            x_cnt   <= '0;
            row     <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_out   <= '0;
            done    <= 1'b0;
            max_abs <= '0;
            res_ok  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                b_buf[i] <= '0;
                x_buf[i] <= '0;
            end
        end else begin
            if (b_we) begin
                b_buf[b_cnt[CW-2:0]] <= b_in;
                b_cnt <= b_cnt + 1'b1;
            end
            if (x_we) begin
                x_buf[x_cnt[CW-2:0]] <= x_in;
                x_cnt <= x_cnt + 1'b1;
            end
            r_valid <= comp;
            done    <= fin;
            if (start) begin
                row     <= '0;
                max_abs <= '0;
                res_ok  <= 1'b0;
            end
            if (comp) begin
                r_idx <= row;
                r_out <= r;
                row   <= row + 1'b1;
                if (r_abs > max_abs) max_abs <= r_abs;
            end
            if (fin) begin
                res_ok <= (max_abs < TOL);
                b_cnt  <= '0;
                x_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gsim_residual.sv
// tb_gsim_residual: directed self-checking bench for gsim_residual.
// Drives b/x frames, captures the residual stream and checks hand values.
module tb_gsim_residual;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [15:0] b_in;
    logic        x_valid;
    logic [31:0] x_in;
    logic        r_valid;
    logic [3:0]  r_idx;
    logic [39:0] r_out;
    logic        done;
    logic [39:0] max_abs;
    logic        res_ok;

    gsim_residual dut (
        .clk     (clk),
        .reset   (reset),
        .in_en   (in_en),
        .b_in    (b_in),
        .x_valid (x_valid),
        .x_in    (x_in),
        .r_valid (r_valid),
        .r_idx   (r_idx),
        .r_out   (r_out),
        .done    (done),
        .max_abs (max_abs),
        .res_ok  (res_ok)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    logic [15:0] bv [17];
    logic [31:0] xv [16];
    logic [39:0] got [16];
    logic [39:0] expv [16];
    logic [39:0] got_max, end_max;
    logic        got_ok, end_ok;
    int rv_cnt, first_rv, last_rv, done_cyc, done_cnt, idx_bad;

    // Band coefficients by distance from the diagonal.
    int coef [4] = '{20, -13, 6, -1};

    function automatic logic [39:0] q16(input int v);
        return 40'(longint'(v) * 65536);
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < 17; i++) bv[i] = 16'h0000;
        for (int i = 0; i < 16; i++) xv[i] = 32'h0;
    endtask

    task automatic impulse_exp(input int j);
        int d;
        for (int i = 0; i < 16; i++) begin
            d = (i > j) ? i - j : j - i;
            expv[i] = (d <= 3) ? q16(coef[d]) : 40'h0;
        end
    endtask

    task automatic drive_frame(input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            in_en = 1'b1;
            b_in  = bv[i];
        end
        @(posedge clk); #1;
        in_en = 1'b0;
        repeat (gap) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            x_valid = 1'b1;
            x_in    = xv[i];
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the 16th x_valid cycle.
    task automatic collect();
        rv_cnt = 0; first_rv = -1; last_rv = -1;
        done_cyc = -1; done_cnt = 0; idx_bad = 0;
        got_max = '1; got_ok = 1'bx;
        for (int i = 0; i < 16; i++) got[i] = '1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (r_valid) begin
                if (r_idx != 4'(rv_cnt)) idx_bad++;
                got[r_idx] = r_out;
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
                rv_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    got_max  = max_abs;
                    got_ok   = res_ok;
                end
            end
        end
        end_max = max_abs;
        end_ok  = res_ok;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_en = 1'b0; b_in = '0; x_valid = 1'b0; x_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({r_valid, r_idx, r_out, done, max_abs, res_ok} !== '0)
            $display("FAIL reset_outputs got rv=%b idx=%0d r=%h done=%b max=%h ok=%b want all 0",
                     r_valid, r_idx, r_out, done, max_abs, res_ok);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_zero();
        clear_vec();
        drive_frame(16, 0);
        collect();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got[i] !== 40'h0)
                $display("FAIL zero_r%0d got %h want 0", i, got[i]);
            else pass_cnt++;
        end
        total++;
        if (rv_cnt !== 16 || done_cnt !== 1)
            $display("FAIL zero_counts got rv=%0d done=%0d want 16/1", rv_cnt, done_cnt);
        else pass_cnt++;
        total++;
        if (got_max !== 40'h0 || got_ok !== 1'b1)
            $display("FAIL zero_max got %h ok=%b want 0 ok=1", got_max, got_ok);
        else pass_cnt++;
    endtask

    task automatic test_impulse(input int j, input logic [39:0] wmax);
        clear_vec();
        xv[j] = 32'h0001_0000;
        impulse_exp(j);
        drive_frame(16, 0);
        collect();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got[i] !== expv[i])
                $display("FAIL imp%0d_r%0d got %h want %h", j, i, got[i], expv[i]);
            else pass_cnt++;
        end
        total++;
        if (got_max !== wmax || got_ok !== 1'b0 || done_cnt !== 1)
            $display("FAIL imp%0d_max got %h ok=%b done=%0d want %h ok=0 done=1",
                     j, got_max, got_ok, done_cnt, wmax);
        else pass_cnt++;
        total++;
        if (idx_bad !== 0)
            $display("FAIL imp%0d_order got %0d bad indices want 0", j, idx_bad);
        else pass_cnt++;
    endtask

    task automatic test_sign();
        clear_vec();
        for (int i = 0; i < 16; i++) bv[i] = 16'hFFFF;
        drive_frame(16, 0);
        collect();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got[i] !== 40'h0000010000)
                $display("FAIL sign_r%0d got %h want 0000010000", i, got[i]);
            else pass_cnt++;
        end
        total++;
        if (got_max !== 40'h0000010000 || got_ok !== 1'b0)
            $display("FAIL sign_max got %h ok=%b want 0000010000 ok=0", got_max, got_ok);
        else pass_cnt++;
    endtask

    task automatic test_overflow_timing();
        clear_vec();
        bv[16] = 16'h7FFF;
        xv[4]  = 32'h0001_0000;
        impulse_exp(4);
        drive_frame(17, 5);
        collect();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got[i] !== expv[i])
                $display("FAIL ovf_r%0d got %h want %h", i, got[i], expv[i]);
            else pass_cnt++;
        end
        total++;
        if (first_rv !== 2)
            $display("FAIL first_rv_latency got %0d want 2", first_rv);
        else pass_cnt++;
        total++;
        if (rv_cnt !== 16 || last_rv !== 17)
            $display("FAIL rv_burst got cnt=%0d last=%0d want 16/17", rv_cnt, last_rv);
        else pass_cnt++;
        total++;
        if (done_cyc !== 18 || done_cnt !== 1)
            $display("FAIL done_timing got cyc=%0d cnt=%0d want 18/1", done_cyc, done_cnt);
        else pass_cnt++;
        total++;
        if (end_max !== 40'h0000140000 || end_ok !== 1'b0)
            $display("FAIL max_hold got %h ok=%b want 0000140000 ok=0", end_max, end_ok);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_vec();
        xv[8] = 32'h0001_0000;
        drive_frame(16, 0);
        seen = 0;
        for (int cyc = 0; cyc < 30 && seen == 0; cyc++) begin
            @(negedge clk);
            if (r_valid && r_idx == 4'd6) seen = 1;
        end
        total++;
        if (seen == 0) begin
            $display("FAIL mid_reach_row7 got timeout want r_idx 6 seen");
        end else begin
            pass_cnt++;
            #2 reset = 1'b1;
            #1;
            total++;
            if ({r_valid, r_idx, r_out, done, max_abs, res_ok} !== '0)
                $display("FAIL mid_reset_outputs got rv=%b idx=%0d r=%h max=%h want all 0",
                         r_valid, r_idx, r_out, max_abs);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse(8, 40'h0000140000);
        test_impulse(0, 40'h0000140000);
        test_impulse(15, 40'h0000140000);
        test_sign();
        test_overflow_timing();
        test_reset_mid();
        test_impulse(8, 40'h0000140000);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
